// File: rtl/slice_write_sched.sv
// Round-robin scheduler that serialises dynamic part-select writes from NREQ requesters
// (plus a full-word clear) into one packed word through a one-deep op register.
module slice_write_sched #(
    parameter int NREQ   = 3,
    parameter int WIDTH  = 8,
    parameter int LANE_W = 4,
    parameter int IDXW   = $clog2(WIDTH),
    parameter int LENW   = $clog2(LANE_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*IDXW-1:0]     req_idx,
    input  logic [NREQ*LENW-1:0]     req_len,
    input  logic [NREQ*LANE_W-1:0]   req_data,
    input  logic                     clr_valid,
    output logic                     clr_ready,
    input  logic [WIDTH-1:0]         clr_value,
    input  logic                     freeze,
    output logic [WIDTH-1:0]         word_q,
    output logic                     commit_valid,
    output logic [$clog2(NREQ):0]    commit_src,
    output logic                     trunc_err
);
    localparam int SRCW = $clog2(NREQ) + 1;
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] l);
        return (l > LENW'(LANE_W)) ? LENW'(LANE_W) : l;
    endfunction

    logic [PTRW-1:0]   rr_q, rr_d, gnt;
    logic              gnt_any, grant_ok, accept;
    int                best_d, d;

    logic [IDXW-1:0]   idx_arr  [NREQ];
    logic [LENW-1:0]   len_arr  [NREQ];
    logic [LANE_W-1:0] data_arr [NREQ];

    logic              op_vld_q;
    logic              op_clr_q;
    logic [SRCW-1:0]   op_src_q;
    logic [IDXW-1:0]   op_idx_q;
    logic [LENW-1:0]   op_len_q;
    logic [WIDTH-1:0]  op_data_q;

    logic [LENW-1:0]         len_eff;
    logic [LANE_W-1:0]       lane_mask;
    logic [WIDTH+LANE_W-1:0] mask_ext, data_ext;
    logic [WIDTH-1:0]        word_d;
    logic                    trunc_d;

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            idx_arr[r]  = req_idx[r*IDXW +: IDXW];
            len_arr[r]  = req_len[r*LENW +: LENW];
            data_arr[r] = req_data[r*LANE_W +: LANE_W];
        end
    end

    // Pick the valid requester with the smallest cyclic distance from rr_q.
    always_comb begin
        best_d  = NREQ;
        d       = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            d = r - int'(rr_q);
            if (d < 0) d = d + NREQ;
            if (req_valid[r] && d < best_d) begin
                best_d  = d;
                gnt     = PTRW'(r);
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        clr_ready = rst_n && !freeze && clr_valid;
        grant_ok  = rst_n && !freeze && !clr_valid && gnt_any;
        accept    = clr_ready || grant_ok;
        for (int r = 0; r < NREQ; r++) begin
            req_ready[r] = grant_ok && (gnt == PTRW'(r));
        end
        rr_d = rr_q;
        if (grant_ok) begin
            rr_d = (gnt == PTRW'(NREQ - 1)) ? '0 : gnt + PTRW'(1);
        end
    end

    // Slice bits shifted past the top of the word land in mask_ext's upper part and flag truncation.
    always_comb begin
        len_eff = clamp_len(op_len_q);
        for (int i = 0; i < LANE_W; i++) begin
            lane_mask[i] = (LENW'(i) < len_eff);
        end
        mask_ext = {{WIDTH{1'b0}}, lane_mask} << op_idx_q;
        data_ext = {{WIDTH{1'b0}}, op_data_q[LANE_W-1:0] & lane_mask} << op_idx_q;
        if (op_clr_q) begin
            word_d  = op_data_q;
            trunc_d = 1'b0;
        end else begin
            word_d  = (word_q & ~mask_ext[WIDTH-1:0]) | data_ext[WIDTH-1:0];
            trunc_d = trunc_err | (|mask_ext[WIDTH+LANE_W-1:WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= '0;
            op_vld_q     <= 1'b0;
            word_q       <= '0;
            commit_valid <= 1'b0;
            commit_src   <= '0;
            trunc_err    <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            op_vld_q     <= accept;
            commit_valid <= op_vld_q;
            if (op_vld_q) begin
                word_q     <= word_d;
                trunc_err  <= trunc_d;
                commit_src <= op_src_q;
            end
        end
    end

    // Op payload is only meaningful while op_vld_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_clr_q  <= clr_ready;
            op_src_q  <= clr_ready ? SRCW'(NREQ) : SRCW'(gnt);
            op_idx_q  <= clr_ready ? '0 : idx_arr[gnt];
            op_len_q  <= clr_ready ? '0 : len_arr[gnt];
            op_data_q <= clr_ready ? clr_value : WIDTH'(data_arr[gnt]);
        end
    end

endmodule

// File: tb/tb_slice_write_sched.sv
// Randomised and directed bench for slice_write_sched against a bit-level reference model.
module tb_slice_write_sched;
    localparam int NREQ = 3, WIDTH = 8, LANE_W = 4, IDXW = 3, LENW = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*IDXW-1:0]   req_idx;
    logic [NREQ*LENW-1:0]   req_len;
    logic [NREQ*LANE_W-1:0] req_data;
    logic                   clr_valid;
    logic                   clr_ready;
    logic [WIDTH-1:0]       clr_value;
    logic                   freeze;
    logic [WIDTH-1:0]       word_q;
    logic                   commit_valid;
    logic [2:0]             commit_src;
    logic                   trunc_err;

    slice_write_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_len(req_len), .req_data(req_data),
        .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_value(clr_value),
        .freeze(freeze), .word_q(word_q), .commit_valid(commit_valid),
        .commit_src(commit_src), .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [WIDTH-1:0] m_word;
    logic             m_cv, m_trunc;
    int               m_src, m_rr;
    logic             m_pv, m_pclr;
    int               m_psrc, m_pidx, m_plen;
    logic [WIDTH-1:0] m_pdata;
    logic [NREQ-1:0]  e_rdy;
    logic             e_clr;
    int               e_g;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_word = '0; m_cv = 0; m_trunc = 0; m_src = 0; m_rr = 0; m_pv = 0;
    endtask

    task automatic model_ready();
        e_rdy = '0; e_clr = 0; e_g = -1;
        if (rst_n && !freeze) begin
            if (clr_valid) e_clr = 1;
            else begin
                for (int k = 0; k < NREQ; k++) begin
                    int r;
                    r = (m_rr + k) % NREQ;
                    if (e_g < 0 && req_valid[r]) e_g = r;
                end
            end
        end
        if (e_g >= 0) e_rdy[e_g] = 1'b1;
    endtask

    task automatic model_edge();
        if (m_pv) begin
            if (m_pclr) begin
                m_word = m_pdata; m_trunc = 0;
            end else begin
                int n;
                n = (m_plen > LANE_W) ? LANE_W : m_plen;
                for (int i = 0; i < n; i++) begin
                    if (m_pidx + i < WIDTH) m_word[m_pidx + i] = m_pdata[i];
                    else m_trunc = 1;
                end
            end
            m_cv = 1; m_src = m_psrc;
        end else m_cv = 0;
        m_pv = 0;
        if (e_clr) begin
            m_pv = 1; m_pclr = 1; m_psrc = NREQ; m_pdata = clr_value;
        end else if (e_g >= 0) begin
            m_pv = 1; m_pclr = 0; m_psrc = e_g;
            m_pidx = int'(req_idx[e_g*IDXW +: IDXW]);
            m_plen = int'(req_len[e_g*LENW +: LENW]);
            m_pdata = WIDTH'(req_data[e_g*LANE_W +: LANE_W]);
            m_rr = (e_g + 1) % NREQ;
        end
    endtask

    task automatic check_outputs();
        check("word_q", 32'(word_q), 32'(m_word));
        check("commit_valid", 32'(commit_valid), 32'(m_cv));
        check("commit_src", 32'(commit_src), 32'(m_src));
        check("trunc_err", 32'(trunc_err), 32'(m_trunc));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        model_ready();
        check("req_ready", 32'(req_ready), 32'(e_rdy));
        check("clr_ready", 32'(clr_ready), 32'(e_clr));
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_idx = '0; req_len = '0; req_data = '0;
        clr_valid = 0; clr_value = '0; freeze = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic set_req(input int r, input int idx, input int len, input int data);
        req_valid[r] = 1'b1;
        req_idx[r*IDXW +: IDXW]     = IDXW'(idx);
        req_len[r*LENW +: LENW]     = LENW'(len);
        req_data[r*LANE_W +: LANE_W] = LANE_W'(data);
    endtask

    task automatic clear_op(input logic [WIDTH-1:0] v);
        clr_valid = 1; clr_value = v; step(); clr_valid = 0; step();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        #2;
        check("reset_word", 32'(word_q), 32'h0);
        check("reset_clr_ready", 32'(clr_ready), 32'h0);
        do_reset();

        // clear A5 appears two edges later with source NREQ
        clear_op(8'hA5);
        check("t1_word", 32'(word_q), 32'hA5);
        check("t1_src", 32'(commit_src), 32'd3);
        check("t1_trunc", 32'(trunc_err), 32'd0);

        // round-robin over three held requesters
        do_reset();
        set_req(0, 0, 1, 1); set_req(1, 2, 1, 1); set_req(2, 4, 1, 1);
        step();
        step(); check("t2_w01", 32'(word_q), 32'h01);
        step(); check("t2_w05", 32'(word_q), 32'h05);
        step(); check("t2_w15", 32'(word_q), 32'h15);
        idle_inputs(); step(); step();

        // clear wins over a simultaneous request, request follows
        clr_valid = 1; clr_value = 8'h3C; set_req(1, 1, 2, 2'b10);
        step();
        clr_valid = 0; step();
        idle_inputs(); step(); step();
        check("t3_word", 32'(word_q), 32'h3C);

        // write running off the top of the word
        clear_op(8'h00);
        set_req(0, 6, 4, 4'hF); step(); idle_inputs(); step();
        check("t4_word", 32'(word_q), 32'hC0);
        check("t4_trunc", 32'(trunc_err), 32'd1);
        clear_op(8'h00);
        check("t4_trunc_clr", 32'(trunc_err), 32'd0);

        // zero-length write, then freeze with valids high
        set_req(2, 3, 0, 4'hF); step(); idle_inputs(); step();
        check("t5_src", 32'(commit_src), 32'd2);
        check("t5_cv", 32'(commit_valid), 32'd1);
        freeze = 1; req_valid = '1;
        repeat (3) step();
        freeze = 0; step(); idle_inputs(); step(); step();

        // reset between accept and commit
        set_req(0, 0, 4, 4'hF); step();
        idle_inputs(); set_req(1, 4, 2, 2'b11); step();
        idle_inputs();
        #1 rst_n = 0;
        #1;
        model_reset();
        check("t6_word", 32'(word_q), 32'h0);
        check("t6_cv", 32'(commit_valid), 32'd0);
        check("t6_src", 32'(commit_src), 32'd0);
        @(posedge clk); #1;
        check("t6_cv_hold", 32'(commit_valid), 32'd0);
        @(negedge clk);
        rst_n = 1;
        step(); step();

        // randomised traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom);
            req_idx   = (NREQ*IDXW)'($urandom);
            req_len   = (NREQ*LENW)'($urandom);
            req_data  = (NREQ*LANE_W)'($urandom);
            clr_valid = ($urandom_range(0, 9) == 0);
            clr_value = WIDTH'($urandom);
            freeze    = ($urandom_range(0, 6) == 0);
            step();
        end
        idle_inputs(); step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
